vector_sweep_checker: RTL and testbench
=======================================

Name: vector_sweep_checker

Overview:
- Clocked stimulus/response engine for the 4-input, 1-output combinational core `mymod` (y = (a&b) | c | d).
- The opposite end of the core's interface: drives a,b,c,d, samples y, and checks it against the golden function.
- Sweeps all 16 input vectors on each `start`, then reports pass/fail, error count and the first failing vector.
- Sits in the bench/BIST layer around the core; replaces hand-written initial-block stimulus.

Parameters:
- SETTLE_CYCLES, 2: wait cycles between applying a vector and sampling y. Legal range 0..15.
- ERR_W, 5: width of the error counter. Counter saturates at all-ones.
- STOP_ON_ERR, 0: when 1, the sweep ends after the first mismatching sample.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep
- dut_y  in  1  core output under test
- drv_a  out  1  core input a = vec[3]
- drv_b  out  1  core input b = vec[2]
- drv_c  out  1  core input c = vec[1]
- drv_d  out  1  core input d = vec[0]
- busy  out  1  sweep in progress
- done  out  1  sweep complete; sticky until the next accepted start or reset
- pass  out  1  done && err_count==0; 0 whenever done==0
- err_count  out  ERR_W  mismatch count, saturating
- first_err_valid  out  1  at least one mismatch this sweep
- first_err_vec  out  4  vector index {a,b,c,d} of the first mismatch

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0, including drv_* and first_err_vec.
  - Vector counter and settle counter 0.
  - Reset mid-sweep aborts the sweep immediately. Next cycle: IDLE, done=0, busy=0.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - Clear err_count, first_err_*, done; set vec=0, busy=1.
  - Go to APPLY.
- APPLY (1 cycle):
  - Register drv_{a,b,c,d} <= vec.
  - Go to SETTLE if SETTLE_CYCLES>0, else to SAMPLE.
- SETTLE: stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - exp = (vec[3]&vec[2]) | vec[1] | vec[0].
  - Mismatch if dut_y !== exp. X/Z on dut_y counts as a mismatch.
  - On mismatch:
    - err_count increments, saturating at 2^ERR_W-1.
    - If first_err_valid==0: set first_err_valid=1 and first_err_vec=vec.
  - End condition: vec==15, or (STOP_ON_ERR && mismatch). On end go to DONE; otherwise vec <= vec+1 and go to APPLY.
  - vec never wraps within a sweep.
- DONE:
  - busy=0, done=1.
  - drv_* hold the last applied vector.
  - err_count and first_err_* hold.
- Latency: the full sweep is 16*(2+SETTLE_CYCLES) cycles from the start-accept edge to the first cycle with done=1 (64 cycles at default).
- Status output timing:
  - busy is 1 from the cycle after start is accepted through the last SAMPLE cycle.
  - done and pass go high on the same edge that busy falls.
- start while busy: ignored, with no effect on counters.
- start and rst in the same cycle: rst wins.
- Golden function is fixed in RTL; there is no runtime reprogramming.

Test Plan:
- Correct core, default params, 1-cycle start:
  - busy=1 on the next cycle.
  - done=1 and pass=1 exactly 64 cycles after the accept edge.
  - err_count=0, first_err_valid=0.
- Core replaced by stuck-at-0 y:
  - err_count=13, first_err_vec=4'b0001, first_err_valid=1, pass=0.
- Stuck-at-0 core, STOP_ON_ERR=1:
  - done 8 cycles after accept.
  - err_count=1, first_err_vec=4'b0001.
  - drv_{a,b,c,d}=0,0,0,1 held in DONE.
- Inverted-y core, ERR_W=3:
  - err_count saturates at 7 (16 raw mismatches).
  - first_err_vec=4'b0000, pass=0.
- Reset and restart:
  - Assert rst for 1 cycle while vec=5. Next cycle: IDLE, all outputs 0.
  - Then start: full clean sweep passes in 64 cycles.
- start handling:
  - start pulsed mid-sweep: no restart, timing unchanged.
  - start pulsed in DONE after a failing sweep against a correct core: counters clear on accept, and the new sweep ends with pass=1.
- SETTLE_CYCLES=0:
  - Sweep completes in 32 cycles.
  - A core model with 1-cycle registered y fails at the first vector whose expected value differs from the previous vector's.

Source files
------------

// File: rtl/vector_sweep_checker.sv
// rtl/vector_sweep_checker.sv - sweeps all 16 vectors through mymod and checks y against (a&b)|c|d
module vector_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5,
  parameter bit STOP_ON_ERR   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_y,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_c,
  output logic             drv_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [3:0]       first_err_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       vec, vec_nxt;
  logic [3:0]       settle_cnt, settle_nxt;
  logic [3:0]       drv, drv_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [ERR_W-1:0] err_q, err_nxt;
  logic             fev_q, fev_nxt;
  logic [3:0]       fvec_q, fvec_nxt;
  logic             exp_y;
  logic             mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 4'd0;
      settle_cnt <= 4'd0;
      drv        <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      fev_q      <= 1'b0;
      fvec_q     <= 4'd0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      settle_cnt <= settle_nxt;
      drv        <= drv_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
      fev_q      <= fev_nxt;
      fvec_q     <= fvec_nxt;
    end
  end

  // Golden model of mymod; X/Z on dut_y must count as a mismatch, hence !==.
  assign exp_y    = (vec[3] & vec[2]) | vec[1] | vec[0];
  assign mismatch = (dut_y !== exp_y);

  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec;
    settle_nxt = settle_cnt;
    drv_nxt    = drv;
    busy_nxt   = busy_q;
    done_nxt   = done_q;
    err_nxt    = err_q;
    fev_nxt    = fev_q;
    fvec_nxt   = fvec_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = APPLY;
          vec_nxt    = 4'd0;
          settle_nxt = 4'd0;
          busy_nxt   = 1'b1;
          done_nxt   = 1'b0;
          err_nxt    = '0;
          fev_nxt    = 1'b0;
          fvec_nxt   = 4'd0;
        end
      end

      APPLY: begin
        drv_nxt    = vec;
        settle_nxt = 4'd0;
        if (SETTLE_CYCLES > 0) state_nxt = SETTLE;
        else                   state_nxt = SAMPLE;
      end

      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_nxt = 4'd0;
          state_nxt  = SAMPLE;
        end else begin
          settle_nxt = settle_cnt + 4'd1;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_nxt = err_q + 1'b1;
          if (!fev_q) begin
            fev_nxt  = 1'b1;
            fvec_nxt = vec;
          end
        end
        // vec stops at 15 rather than wrapping so DONE still reports the last vector.
        if ((vec == 4'd15) || (STOP_ON_ERR && mismatch)) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          vec_nxt   = vec + 4'd1;
          state_nxt = APPLY;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  assign drv_a           = drv[3];
  assign drv_b           = drv[2];
  assign drv_c           = drv[1];
  assign drv_d           = drv[0];
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// tb/tb_vector_sweep_checker.sv - scoreboard bench for vector_sweep_checker across four parameter sets
module tb_vector_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s [4];
  logic       dut_y_s [4];
  logic       a_s [4], b_s [4], c_s [4], d_s [4];
  logic       busy_s [4], done_s [4], pass_s [4], fev_s [4];
  logic [3:0] fvec_s [4];
  logic [4:0] err_i0, err_i1, err_i3;
  logic [2:0] err_i2;
  logic [4:0] err_s [4];

  int settle_p [4] = '{2, 2, 2, 0};
  int errw_p   [4] = '{5, 5, 3, 5};
  bit stop_p   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // Core behaviours: 0 correct, 1 stuck-at-0, 2 inverted, 3 registered y.
  int         mode [4];
  logic       yreg [4];
  logic [3:0] prev_drv [4];

  typedef struct {
    int         cycles;
    logic [4:0] err;
    logic       fev;
    logic [3:0] fvec;
    logic       pss;
    logic [3:0] last;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic golden(input logic [3:0] v);
    return (v[3] & v[2]) | v[1] | v[0];
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 4; i++) yreg[i] <= golden({a_s[i], b_s[i], c_s[i], d_s[i]});

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dut_y_s[i] = golden({a_s[i], b_s[i], c_s[i], d_s[i]});
      case (mode[i])
        1:       dut_y_s[i] = 1'b0;
        2:       dut_y_s[i] = ~golden({a_s[i], b_s[i], c_s[i], d_s[i]});
        3:       dut_y_s[i] = yreg[i];
        default: dut_y_s[i] = golden({a_s[i], b_s[i], c_s[i], d_s[i]});
      endcase
    end
  end

  always_comb begin
    err_s[0] = err_i0;
    err_s[1] = err_i1;
    err_s[2] = {2'b00, err_i2};
    err_s[3] = err_i3;
  end

  vector_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(5), .STOP_ON_ERR(1'b0)) u_def (
    .clk(clk), .rst(rst), .start(start_s[0]), .dut_y(dut_y_s[0]),
    .drv_a(a_s[0]), .drv_b(b_s[0]), .drv_c(c_s[0]), .drv_d(d_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_i0),
    .first_err_valid(fev_s[0]), .first_err_vec(fvec_s[0]));

  vector_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(5), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start_s[1]), .dut_y(dut_y_s[1]),
    .drv_a(a_s[1]), .drv_b(b_s[1]), .drv_c(c_s[1]), .drv_d(d_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_i1),
    .first_err_valid(fev_s[1]), .first_err_vec(fvec_s[1]));

  vector_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(3), .STOP_ON_ERR(1'b0)) u_sat (
    .clk(clk), .rst(rst), .start(start_s[2]), .dut_y(dut_y_s[2]),
    .drv_a(a_s[2]), .drv_b(b_s[2]), .drv_c(c_s[2]), .drv_d(d_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err_i2),
    .first_err_valid(fev_s[2]), .first_err_vec(fvec_s[2]));

  vector_sweep_checker #(.SETTLE_CYCLES(0), .ERR_W(5), .STOP_ON_ERR(1'b0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_s[3]), .dut_y(dut_y_s[3]),
    .drv_a(a_s[3]), .drv_b(b_s[3]), .drv_c(c_s[3]), .drv_d(d_s[3]),
    .busy(busy_s[3]), .done(done_s[3]), .pass(pass_s[3]), .err_count(err_i3),
    .first_err_valid(fev_s[3]), .first_err_vec(fvec_s[3]));

  function automatic exp_t predict(input int inst, input int m);
    exp_t       e;
    int         raw;
    int         nvec;
    int         maxv;
    logic [3:0] v;
    logic [3:0] prev;
    logic       ex, ym;
    raw    = 0;
    nvec   = 0;
    v      = 4'd0;
    prev   = prev_drv[inst];
    e.fev  = 1'b0;
    e.fvec = 4'd0;
    for (int k = 0; k < 16; k++) begin
      v  = 4'(k);
      ex = golden(v);
      case (m)
        1:       ym = 1'b0;
        2:       ym = ~ex;
        3:       ym = (settle_p[inst] == 0) ? golden(prev) : ex;
        default: ym = ex;
      endcase
      prev = v;
      nvec++;
      if (ym !== ex) begin
        raw++;
        if (!e.fev) begin
          e.fev  = 1'b1;
          e.fvec = v;
        end
        if (stop_p[inst]) break;
      end
    end
    maxv     = (1 << errw_p[inst]) - 1;
    e.cycles = nvec * (2 + settle_p[inst]);
    e.err    = 5'((raw > maxv) ? maxv : raw);
    e.pss    = (raw == 0);
    e.last   = v;
    return e;
  endfunction

  task automatic run_sweep(input int inst, input int m, input bit mid_start, input string tag);
    exp_t e;
    int   k;
    mode[inst] = m;
    sb.push_back(predict(inst, m));
    @(negedge clk); start_s[inst] = 1'b1;
    @(negedge clk); start_s[inst] = 1'b0;
    n_checks++;
    if ({busy_s[inst], done_s[inst], pass_s[inst], fev_s[inst]} !== 4'b1000 || err_s[inst] !== 5'd0)
      $display("FAIL %s accept: busy/done/pass/fev=%b err=%0d required 1000 err=0", tag,
               {busy_s[inst], done_s[inst], pass_s[inst], fev_s[inst]}, err_s[inst]);
    else n_pass++;
    k = 0;
    while (done_s[inst] !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
      start_s[inst] = (mid_start && k == 10);
    end
    start_s[inst] = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (k != e.cycles) $display("FAIL %s latency: got %0d cycles required %0d", tag, k, e.cycles);
    else n_pass++;
    n_checks++;
    if (err_s[inst] !== e.err) $display("FAIL %s err_count: got %0d required %0d", tag, err_s[inst], e.err);
    else n_pass++;
    n_checks++;
    if (fev_s[inst] !== e.fev || fvec_s[inst] !== e.fvec)
      $display("FAIL %s first_err: got valid=%b vec=%b required valid=%b vec=%b", tag,
               fev_s[inst], fvec_s[inst], e.fev, e.fvec);
    else n_pass++;
    n_checks++;
    if (pass_s[inst] !== e.pss || busy_s[inst] !== 1'b0)
      $display("FAIL %s pass/busy: got %b/%b required %b/0", tag, pass_s[inst], busy_s[inst], e.pss);
    else n_pass++;
    n_checks++;
    if ({a_s[inst], b_s[inst], c_s[inst], d_s[inst]} !== e.last)
      $display("FAIL %s drv: got %b required %b", tag, {a_s[inst], b_s[inst], c_s[inst], d_s[inst]}, e.last);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_s[inst] !== 1'b1 || err_s[inst] !== e.err)
      $display("FAIL %s sticky: done=%b err=%0d required done=1 err=%0d", tag, done_s[inst], err_s[inst], e.err);
    else n_pass++;
    prev_drv[inst] = e.last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_s[i]  = 1'b0;
      mode[i]     = 0;
      prev_drv[i] = 4'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({a_s[i], b_s[i], c_s[i], d_s[i], busy_s[i], done_s[i], pass_s[i], fev_s[i]} !== 8'd0 ||
          err_s[i] !== 5'd0 || fvec_s[i] !== 4'd0)
        $display("FAIL reset inst%0d: drv/busy/done/pass/fev=%b err=%0d fvec=%b required all 0", i,
                 {a_s[i], b_s[i], c_s[i], d_s[i], busy_s[i], done_s[i], pass_s[i], fev_s[i]},
                 err_s[i], fvec_s[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clean_sweep();
    run_sweep(0, 0, 1'b0, "clean");
  endtask

  task automatic test_stuck_at_zero();
    run_sweep(0, 1, 1'b0, "stuck0");
  endtask

  task automatic test_restart_after_fail();
    run_sweep(0, 0, 1'b0, "restart_after_fail");
  endtask

  task automatic test_stop_on_err();
    run_sweep(1, 1, 1'b0, "stop_on_err");
  endtask

  task automatic test_saturation();
    run_sweep(2, 2, 1'b0, "saturate");
  endtask

  task automatic test_mid_start();
    run_sweep(0, 0, 1'b1, "mid_start");
  endtask

  task automatic test_reset_mid_sweep();
    int k;
    mode[0] = 0;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    k = 0;
    while ({a_s[0], b_s[0], c_s[0], d_s[0]} !== 4'd5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 200) $display("FAIL reset_mid reach_vec5: got timeout required drv=0101");
    else n_pass++;
    rst = 1'b1;
    start_s[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_s[0] = 1'b0;
    n_checks++;
    if ({a_s[0], b_s[0], c_s[0], d_s[0], busy_s[0], done_s[0], pass_s[0], fev_s[0]} !== 8'd0 ||
        err_s[0] !== 5'd0 || fvec_s[0] !== 4'd0)
      $display("FAIL reset_mid outputs: drv/busy/done/pass/fev=%b err=%0d required all 0",
               {a_s[0], b_s[0], c_s[0], d_s[0], busy_s[0], done_s[0], pass_s[0], fev_s[0]}, err_s[0]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy_s[0] !== 1'b0) $display("FAIL reset_wins_start busy: got %b required 0", busy_s[0]);
    else n_pass++;
    for (int i = 0; i < 4; i++) prev_drv[i] = 4'd0;
    run_sweep(0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_settle_zero();
    run_sweep(3, 0, 1'b0, "settle0_clean");
    run_sweep(3, 3, 1'b0, "settle0_regcore");
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_stuck_at_zero();
    test_restart_after_fail();
    test_stop_on_err();
    test_saturation();
    test_mid_start();
    test_reset_mid_sweep();
    test_settle_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
